// File: rtl/mutation_arbiter.sv
// -----------------------------------------------------------------------------
// mutation_arbiter
//
// Shares a single free-running mutation unit between N_REQ crossover lanes.
// Pairs are admitted round-robin into an issue register (stage A) that feeds
// the mutation unit directly. A tag shadow (stage M) follows the unit's own
// one-cycle register, so the returning mutated pair can be labelled with its
// requester. Results are pushed into an in-order result FIFO (stage R) and
// handed back on a shared response bus with a one-hot resp_valid.
//
// Admission is credit based. Every slot that could still turn into a FIFO
// push (A, M, and the FIFO entries themselves) is counted against RES_DEPTH,
// so a push can never meet a full FIFO and the non-stallable unit never loses
// a result.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-high, clears all state
//   req_valid      : [N_REQ]   requester i presents a pair
//   req_ready      : [N_REQ]   one-hot (or zero) grant, combinational
//   req_child1/2   : [N_REQ*8] packed signed children, lane i at [8i+7:8i]
//   mu_orig_child* : signed 8  issue register contents to the mutation unit
//   mu_mut_child*  : signed 8  mutation unit outputs (one cycle later)
//   resp_valid     : [N_REQ]   one-hot (or zero), bit of the FIFO head's tag
//   resp_ready     : [N_REQ]   only the head tag's bit is honoured
//   resp_child*    : signed 8  FIFO head data, zero while empty
//   busy           : any stage holds a valid entry
// -----------------------------------------------------------------------------
module mutation_arbiter #(
  parameter int N_REQ     = 4,
  parameter int RES_DEPTH = 4,
  localparam int TAG_W    = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*8-1:0]    req_child1,
  input  logic [N_REQ*8-1:0]    req_child2,
  output logic signed [7:0]     mu_orig_child1,
  output logic signed [7:0]     mu_orig_child2,
  input  logic signed [7:0]     mu_mut_child1,
  input  logic signed [7:0]     mu_mut_child2,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic signed [7:0]     resp_child1,
  output logic signed [7:0]     resp_child2,
  output logic                  busy
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  // Issue stage (A)
  logic                vld_a;
  logic [TAG_W-1:0]    tag_a;
  logic signed [7:0]   orig1_a;
  logic signed [7:0]   orig2_a;

  // Shadow of the mutation unit register (M)
  logic                vld_m;
  logic [TAG_W-1:0]    tag_m;

  // Result FIFO (R)
  logic [TAG_W-1:0]    tag_mem [RES_DEPTH];
  logic signed [7:0]   c1_mem  [RES_DEPTH];
  logic signed [7:0]   c2_mem  [RES_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  // Round-robin pointer: index of the last granted requester
  logic [TAG_W-1:0]    last;

  // Combinational control
  logic [OCC_W-1:0]    occ;
  logic                credit;
  logic                found;
  logic [TAG_W-1:0]    winner;
  logic                accept;
  logic signed [7:0]   grant_c1;
  logic signed [7:0]   grant_c2;
  logic                fifo_empty;
  logic [TAG_W-1:0]    head_tag;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap keeps non-power-of-two depths correct.
    if (p == PTR_W'(RES_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Everything that may still land in the FIFO holds a credit; a pop in the
  // current cycle only returns its credit once the count has dropped.
  always_comb begin
    occ    = OCC_W'(count) + OCC_W'(vld_a) + OCC_W'(vld_m);
    credit = (occ < OCC_W'(RES_DEPTH));
  end

  // Scan last+1 .. last+N_REQ (mod N_REQ); first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [TAG_W-1:0] idx;
      idx = TAG_W'((int'(last) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    accept    = found && credit;
    req_ready = '0;
    // Held at zero while reset is asserted, even though the scan would
    // already point at requester 0.
    if (accept && !reset) req_ready[winner] = 1'b1;
    grant_c1  = req_child1[8*int'(winner) +: 8];
    grant_c2  = req_child2[8*int'(winner) +: 8];
  end

  always_comb begin
    fifo_empty = (count == '0);
    head_tag   = tag_mem[rd_ptr];
    push       = vld_m;
    pop        = !fifo_empty && resp_ready[head_tag];
    resp_valid = '0;
    if (!fifo_empty) resp_valid[head_tag] = 1'b1;
    resp_child1 = fifo_empty ? 8'sd0 : c1_mem[rd_ptr];
    resp_child2 = fifo_empty ? 8'sd0 : c2_mem[rd_ptr];
    busy        = vld_a || vld_m || !fifo_empty;
  end

  assign mu_orig_child1 = orig1_a;
  assign mu_orig_child2 = orig2_a;

  // ---- stage A: issue register / round-robin pointer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_a   <= 1'b0;
      tag_a   <= '0;
      orig1_a <= 8'sd0;
      orig2_a <= 8'sd0;
      last    <= TAG_W'(N_REQ - 1);
    end else begin
      vld_a <= accept;
      if (accept) begin
        tag_a   <= winner;
        orig1_a <= grant_c1;
        orig2_a <= grant_c2;
        last    <= winner;
      end
    end
  end

  // ---- stage M: tag shadow of the mutation unit register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_m <= 1'b0;
      tag_m <= '0;
    end else begin
      vld_m <= vld_a;
      tag_m <= tag_a;
    end
  end

  // ---- stage R: result FIFO control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage carries no reset; the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= tag_m;
      c1_mem[wr_ptr]  <= mu_mut_child1;
      c2_mem[wr_ptr]  <= mu_mut_child2;
    end
  end

endmodule

// File: tb/tb_mutation_arbiter.sv
module tb_mutation_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_child1;
  logic [N*8-1:0] req_child2;
  logic [7:0]     mu_orig_child1, mu_orig_child2;
  logic [7:0]     mu_mut_child1, mu_mut_child2;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [7:0]     resp_child1, resp_child2;
  logic           busy;

  logic [7:0]     c1_l [N];
  logic [7:0]     c2_l [N];
  logic           mode;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] tag;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl[17];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_child1 = '0;
    req_child2 = '0;
    for (int i = 0; i < N; i++) begin
      req_child1[8*i +: 8] = c1_l[i];
      req_child2[8*i +: 8] = c2_l[i];
    end
  end

  mutation_arbiter #(.N_REQ(N), .RES_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_child1(req_child1), .req_child2(req_child2),
    .mu_orig_child1(mu_orig_child1), .mu_orig_child2(mu_orig_child2),
    .mu_mut_child1(mu_mut_child1), .mu_mut_child2(mu_mut_child2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_child1(resp_child1), .resp_child2(resp_child2),
    .busy(busy)
  );

  // Mutation unit stand-in: identity when mode=0, a fixed mixing function
  // otherwise; one register of latency, reset by the same net.
  function automatic logic [7:0] mf1(input logic m, input logic [7:0] a, input logic [7:0] b);
    return m ? (a ^ {b[3:0], b[7:4]}) : a;
  endfunction
  function automatic logic [7:0] mf2(input logic m, input logic [7:0] a, input logic [7:0] b);
    return m ? (b - a) : b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mu_mut_child1 <= '0;
      mu_mut_child2 <= '0;
    end else begin
      mu_mut_child1 <= mf1(mode, mu_orig_child1, mu_orig_child2);
      mu_mut_child2 <= mf2(mode, mu_orig_child1, mu_orig_child2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: accepted pairs are queued, responses compared at head.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.tag = 2'(i);
          e.c1  = mf1(mode, req_child1[8*i +: 8], req_child2[8*i +: 8]);
          e.c2  = mf2(mode, req_child1[8*i +: 8], req_child2[8*i +: 8]);
          sbq.push_back(e);
        end
      end
      if (resp_valid != '0) begin
        int t;
        t = 0;
        check("resp_onehot", {31'd0, $onehot(resp_valid)}, 32'd1);
        for (int i = 0; i < N; i++) if (resp_valid[i]) t = i;
        if (sbq.size() == 0) begin
          check("resp_unexpected", {28'd0, resp_valid}, 32'd0);
        end else begin
          check("resp_tag", t, {30'd0, sbq[0].tag});
          check("resp_c1", {24'd0, resp_child1}, {24'd0, sbq[0].c1});
          check("resp_c2", {24'd0, resp_child2}, {24'd0, sbq[0].c2});
          if (resp_ready[t]) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    sbq.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    req_valid  = '0;
    resp_ready = '1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, {31'd0, busy}, 32'd0);
    check({name, "_sb"}, sbq.size(), 32'd0);
  endtask

  initial begin
    int nacc;
    int issued;
    logic [N-1:0] acc_v;
    logic [7:0] h1;

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b0101, 4'b0100};
    tbl[7]  = '{4'b0011, 4'b0001};
    tbl[8]  = '{4'b1000, 4'b1000};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1001, 4'b0001};
    tbl[11] = '{4'b1001, 4'b1000};
    tbl[12] = '{4'b0110, 4'b0010};
    tbl[13] = '{4'b0110, 4'b0100};
    tbl[14] = '{4'b0000, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0000};

    mode       = 1'b0;
    reset      = 1'b1;
    req_valid  = '1;
    resp_ready = '0;
    for (int i = 0; i < N; i++) begin
      c1_l[i] = 8'(i + 1);
      c2_l[i] = 8'(i + 9);
    end

    // Reset state, with requests already presented
    @(negedge clk);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mu_orig1", {24'd0, mu_orig_child1}, 32'd0);
    check("rst_resp_c1", {24'd0, resp_child1}, 32'd0);
    @(posedge clk);
    #2;
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk);
    #1;

    // Single request on lane 2, identity mutation
    c1_l[2]   = 8'h5A;
    c2_l[2]   = 8'hFD;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", {28'd0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("single_mu_o1", {24'd0, mu_orig_child1}, 32'h5A);
    check("single_mu_o2", {24'd0, mu_orig_child2}, 32'hFD);
    check("single_lat1", {28'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("single_lat2", {28'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 4'b0100;
    @(negedge clk);
    check("single_resp_v", {28'd0, resp_valid}, 32'h4);
    check("single_resp_c1", {24'd0, resp_child1}, 32'h5A);
    check("single_resp_c2", {24'd0, resp_child2}, 32'hFD);
    @(posedge clk);
    #1;
    check("single_busy", {31'd0, busy}, 32'd0);

    // Round-robin table: grant per row, response three rows later
    do_reset();
    resp_ready = '1;
    for (int r = 0; r < 17; r++) begin
      req_valid = tbl[r].valid;
      for (int i = 0; i < N; i++) begin
        c1_l[i] = 8'($urandom);
        c2_l[i] = 8'($urandom);
      end
      @(negedge clk);
      check($sformatf("rr_grant_%0d", r), {28'd0, req_ready}, {28'd0, tbl[r].exp_ready});
      check($sformatf("rr_resp_%0d", r), {28'd0, resp_valid},
            (r >= 3) ? {28'd0, tbl[r-3].exp_ready} : 32'd0);
      @(posedge clk);
      #1;
    end
    drain("rr_drain");

    // Backpressure: only the FIFO depth worth of pairs is admitted
    do_reset();
    resp_ready = '0;
    req_valid  = 4'b0010;
    nacc = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready[1]) nacc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts", nacc, 32'd4);
    @(negedge clk);
    check("bp_ready_low", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 4'b0010;
    @(posedge clk);
    #1;
    resp_ready = '0;
    nacc = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready[1]) nacc++;
      @(posedge clk);
      #1;
    end
    check("bp_one_more", nacc, 32'd1);
    drain("bp_drain");

    // Misrouted ready: head tag 3 must not be popped by other bits
    do_reset();
    resp_ready = 4'b0111;
    c1_l[3]    = 8'hC3;
    c2_l[3]    = 8'h3C;
    req_valid  = 4'b1000;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    h1 = resp_child1;
    check("mis_head_v", {28'd0, resp_valid}, 32'h8);
    check("mis_head_c1", {24'd0, h1}, 32'hC3);
    // Head stays put; credits show the count is still one
    req_valid = 4'b0001;
    nacc = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready[0]) nacc++;
      @(posedge clk);
      #1;
    end
    check("mis_credits", nacc, 32'd3);
    check("mis_head_v2", {28'd0, resp_valid}, 32'h8);
    check("mis_head_c1b", {24'd0, resp_child1}, 32'hC3);
    drain("mis_drain");

    // Reset mid-flight with A, M and FIFO occupied
    do_reset();
    resp_ready = '0;
    req_valid  = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    check("mid_resp_pre", {28'd0, resp_valid}, 32'h1);
    #1;
    reset = 1'b1;
    sbq.delete();
    #1;
    check("mid_ready", {28'd0, req_ready}, 32'd0);
    check("mid_resp", {28'd0, resp_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2;
    reset      = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    #1;
    check("mid_first_grant", {28'd0, req_ready}, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    drain("mid_drain");

    // Randomized run: 1000 pairs, mixing mutation, random backpressure
    mode = 1'b1;
    do_reset();
    issued = 0;
    req_valid = '0;
    for (int cyc = 0; cyc < 20000 && issued < 1000; cyc++) begin
      @(negedge clk);
      acc_v = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (acc_v[i]) issued++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_v[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0) && (issued < 1000);
          c1_l[i] = 8'($urandom);
          c2_l[i] = 8'($urandom);
        end
      end
      if (issued >= 1000) req_valid = '0;
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
    end
    check("rand_issued", issued, 32'd1000);
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
